waterfall_buffer: RTL and testbench

- Spectrogram history store sitting directly upstream of the screen generator's waterfall pixel input.
- Accepts one spectrum line at a time (8-bit dB per bin) from the power/FFT stage and writes it into a circular RAM of WATERFALLSIZE lines.
- Returns the pixel for the requested row/column as the raster sweeps, newest line at the top.
- One pixel clock domain; producer and display share clk.

---
 rtl/waterfall_buffer.sv | 180 ++++++++++++++++++
 tb/tb_waterfall_buffer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/waterfall_buffer.sv
// Circular spectrogram history with raster readback, newest line on top.
// Define WF_PEAK_EN to fold DECIMATE input lines into one committed line by per-bin max.
module waterfall_buffer #(
    parameter int LINEWIDTH     = 1024,
    parameter int WATERFALLSIZE = 256,
    parameter int DECIMATE      = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [7:0]                       i_bin_data,
    input  logic                             i_bin_valid,
    input  logic                             i_bin_last,
    output logic                             o_bin_ready,
    input  logic                             i_wf_sync,
    input  logic                             i_hs,
    input  logic [$clog2(LINEWIDTH)-1:0]     i_addr,
    output logic [7:0]                       o_wfPixel,
    output logic [$clog2(WATERFALLSIZE):0]   o_fill,
    output logic                             o_overflow
);
    localparam int CW = $clog2(LINEWIDTH);
    localparam int LW = $clog2(WATERFALLSIZE);
`ifdef WF_PEAK_EN
    localparam bit PEAK_EN = 1'b1;
`else
    localparam bit PEAK_EN = 1'b0;
`endif
    localparam int DEC_N = PEAK_EN ? DECIMATE : 1;
    localparam int DW    = (DEC_N > 1) ? $clog2(DEC_N) : 1;
    localparam logic [DW-1:0] DEC_LAST = DW'(DEC_N - 1);
    localparam logic [LW:0]   FULL     = (LW+1)'(WATERFALLSIZE);

    typedef enum logic [1:0] {IDLE, FILL, COMMIT} state_t;

    logic [7:0]       mem [WATERFALLSIZE*LINEWIDTH];
    state_t           state;
    logic [LW-1:0]    wr_line;
    logic [CW:0]      col;
    logic [DW-1:0]    dec_cnt;
    logic             accept, in_range, do_commit;
    logic             wr_en;
    logic [LW+CW-1:0] wr_addr;
    logic [7:0]       wr_data;

    assign accept    = i_bin_valid & o_bin_ready;
    assign in_range  = ~col[CW];
    assign do_commit = (dec_cnt == DEC_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            o_bin_ready <= 1'b0;
            wr_line     <= '0;
            col         <= '0;
            dec_cnt     <= '0;
            o_fill      <= '0;
            o_overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE, FILL: begin
                    o_bin_ready <= 1'b1;
                    if (accept) begin
                        // col parks at LINEWIDTH so surplus bins are dropped
                        if (in_range) col <= col + (CW+1)'(1);
                        else          o_overflow <= 1'b1;
                        if (i_bin_last) begin
                            col     <= '0;
                            dec_cnt <= do_commit ? '0 : dec_cnt + DW'(1);
                            if (do_commit) begin
                                state       <= COMMIT;
                                o_bin_ready <= 1'b0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            state <= FILL;
                        end
                    end
                end
                COMMIT: begin
                    wr_line     <= wr_line + LW'(1);
                    if (o_fill != FULL) o_fill <= o_fill + (LW+1)'(1);
                    state       <= IDLE;
                    o_bin_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WF_PEAK_EN
    // Scratch line holds the running max; one-cycle read pipeline with bypass
    logic [7:0]       scr [LINEWIDTH];
    logic             p_vld, p_first, p_hist, byp_q;
    logic [CW-1:0]    p_col;
    logic [LW+CW-1:0] p_addr;
    logic [7:0]       p_data, scr_q, byp_d, prev, peak;

    assign prev = byp_q ? byp_d : scr_q;
    assign peak = (p_first || p_data > prev) ? p_data : prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_vld   <= 1'b0;
            p_first <= 1'b0;
            p_hist  <= 1'b0;
            p_col   <= '0;
            p_addr  <= '0;
            p_data  <= '0;
            byp_q   <= 1'b0;
            byp_d   <= '0;
        end else begin
            p_vld   <= accept & in_range;
            p_first <= (dec_cnt == '0);
            p_hist  <= do_commit;
            p_col   <= col[CW-1:0];
            p_addr  <= {wr_line, col[CW-1:0]};
            p_data  <= i_bin_data;
            byp_q   <= p_vld && (p_col == col[CW-1:0]);
            byp_d   <= peak;
        end
    end

    always_ff @(posedge clk) begin
        if (p_vld) scr[p_col] <= peak;
        scr_q <= scr[col[CW-1:0]];
    end

    assign wr_en   = p_vld & p_hist;
    assign wr_addr = p_addr;
    assign wr_data = peak;
`else
    assign wr_en   = accept & in_range;
    assign wr_addr = {wr_line, col[CW-1:0]};
    assign wr_data = i_bin_data;
`endif

    logic          sync_d, hs_d, pending, blank_q;
    logic [LW-1:0] top_line;
    logic [LW:0]   age;
    logic [7:0]    rd_q;
    logic [LW+CW-1:0] rd_addr;

    assign rd_addr = {top_line - age[LW-1:0], i_addr};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_d   <= 1'b0;
            hs_d     <= 1'b0;
            pending  <= 1'b0;
            top_line <= '0;
            age      <= FULL;
            blank_q  <= 1'b1;
        end else begin
            sync_d <= i_wf_sync;
            hs_d   <= i_hs;
            if (i_wf_sync && !sync_d) begin
                top_line <= wr_line - LW'(1);
                pending  <= 1'b1;
            end else if (i_hs && !hs_d) begin
                if (pending) begin
                    age     <= '0;
                    pending <= 1'b0;
                end else if (age != FULL) begin
                    age <= age + (LW+1)'(1);
                end
            end
            blank_q <= (age >= o_fill) || age[LW];
        end
    end

    // Read-first simple dual-port history RAM
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_q <= mem[rd_addr];
    end

    assign o_wfPixel = blank_q ? 8'd0 : rd_q;

endmodule

// File: tb/tb_waterfall_buffer.sv
// Scoreboard bench for waterfall_buffer: random lines and raster reads against a line-history model.
module tb_waterfall_buffer;
    localparam int LW  = 32;
    localparam int WF  = 16;
    localparam int DEC = 4;
    localparam int CW  = $clog2(LW);
    localparam int FW  = $clog2(WF) + 1;
`ifdef WF_PEAK_EN
    localparam bit PEAK = 1'b1;
`else
    localparam bit PEAK = 1'b0;
`endif

    logic          clk = 1'b0, rst_n = 1'b0;
    logic [7:0]    i_bin_data = '0;
    logic          i_bin_valid = 1'b0, i_bin_last = 1'b0, o_bin_ready;
    logic          i_wf_sync = 1'b0, i_hs = 1'b0;
    logic [CW-1:0] i_addr = '0;
    logic [7:0]    o_wfPixel;
    logic [FW-1:0] o_fill;
    logic          o_overflow;

    always #5 clk = ~clk;

    waterfall_buffer #(.LINEWIDTH(LW), .WATERFALLSIZE(WF), .DECIMATE(DEC)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_bin_data(i_bin_data), .i_bin_valid(i_bin_valid), .i_bin_last(i_bin_last),
        .o_bin_ready(o_bin_ready),
        .i_wf_sync(i_wf_sync), .i_hs(i_hs), .i_addr(i_addr),
        .o_wfPixel(o_wfPixel), .o_fill(o_fill), .o_overflow(o_overflow)
    );

    typedef logic [LW-1:0][7:0] line_t;
    line_t      lines[$];      // every committed line, oldest first
    line_t      acc;
    int         grp = 0, in_lines = 0, snap_n = 0;
    bit         exp_ovf = 1'b0;
    logic [7:0] stim [LW+8];
    logic [7:0] sb[$];
    logic       rd_req = 1'b0, rd_d = 1'b0;
    int         vectors = 0, miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) rd_d <= rd_req;
    always @(negedge clk) begin
        if (rd_d) begin
            if (sb.size() == 0) begin
                vectors++; miscompares++;
                $display("FAIL pixel: output with no expected entry at %0t", $time);
            end else begin
                check("pixel", {24'd0, o_wfPixel}, {24'd0, sb.pop_front()});
            end
        end
    end

    function automatic logic [7:0] exp_pix(input int r, input int c);
        if (r < WF && r < snap_n) return lines[snap_n-1-r][c];
        return 8'd0;
    endfunction

    // Untouched columns of a short line keep whatever the slot held WF commits ago
    function automatic void model_line(input int nbins);
        line_t ln;
        int n = lines.size();
        ln = (n >= WF) ? lines[n-WF] : '0;
        for (int c = 0; c < LW && c < nbins; c++) ln[c] = stim[c];
        if (nbins > LW) exp_ovf = 1'b1;
        if (PEAK) begin
            for (int c = 0; c < LW; c++)
                if (grp == 0 || ln[c] > acc[c]) acc[c] = ln[c];
            grp++;
            if (grp == DEC) begin
                grp = 0;
                lines.push_back(acc);
            end
        end else begin
            lines.push_back(ln);
        end
    endfunction

    function automatic void fill_const(input int v);
        for (int c = 0; c < LW+8; c++) stim[c] = 8'(v);
    endfunction

    function automatic void fill_rand();
        for (int c = 0; c < LW+8; c++) stim[c] = 8'($urandom);
    endfunction

    task automatic send_line(input int nbins);
        int i = 0, guard = 0;
        bit acc_b, commit_exp;
        commit_exp = !PEAK || (grp == DEC-1);
        while (i < nbins && guard < 20*nbins + 50) begin
            i_bin_valid = ($urandom_range(0, 3) != 0);
            i_bin_data  = stim[i];
            i_bin_last  = (i == nbins-1);
            @(negedge clk);
            acc_b = i_bin_valid && o_bin_ready;
            @(posedge clk); #1;
            if (acc_b) i++;
            guard++;
        end
        i_bin_valid = 1'b0;
        i_bin_last  = 1'b0;
        if (i < nbins) begin
            vectors++; miscompares++;
            $display("FAIL line_accept: accepted %0d of %0d bins before timeout", i, nbins);
        end
        @(negedge clk);
        check("ready_after_last", {31'd0, o_bin_ready}, commit_exp ? 32'd0 : 32'd1);
        @(negedge clk);
        check("ready_back", {31'd0, o_bin_ready}, 32'd1);
        @(posedge clk); #1;
        model_line(nbins);
        in_lines++;
        check("fill", {27'd0, o_fill}, (lines.size() < WF) ? lines.size() : WF);
        check("overflow", {31'd0, o_overflow}, {31'd0, exp_ovf});
    endtask

    // Raster one frame plus two rows past the end; optionally commit a line before row mid_row
    task automatic frame(input int mid_row);
        bit torn = 1'b0;
        int n0, c;
        i_wf_sync = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        i_wf_sync = 1'b0;
        snap_n = lines.size();
        for (int r = 0; r <= WF+1; r++) begin
            if (r == mid_row) begin
                n0 = lines.size();
                while (lines.size() == n0) begin fill_rand(); send_line(LW); end
                torn = 1'b1;
            end
            i_hs = 1'b1;
            @(posedge clk); #1;
            i_hs = 1'b0;
            for (int k = 0; k < 6; k++) begin
                c = (k == 0) ? 0 : (k == 1) ? LW-1 : (k == 2) ? 5 : $urandom_range(0, LW-1);
                i_addr = CW'(c);
                if (torn && r == WF-1) rd_req = 1'b0;
                else begin
                    sb.push_back(exp_pix(r, c));
                    rd_req = 1'b1;
                end
                @(posedge clk); #1;
            end
            rd_req = 1'b0;
            i_addr = CW'($urandom);
            repeat (2) begin @(posedge clk); #1; end
        end
        check("sb_drained", sb.size(), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int pk[4] = '{3, 9, 2, 7};
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {31'd0, o_bin_ready}, 32'd0);
        check("rst_pixel", {24'd0, o_wfPixel}, 32'd0);
        check("rst_fill", {27'd0, o_fill}, 32'd0);
        check("rst_overflow", {31'd0, o_overflow}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_idle", {31'd0, o_bin_ready}, 32'd1);

        frame(-1);
        check("fill_empty", {27'd0, o_fill}, 32'd0);

        fill_const(10); send_line(LW);
        fill_const(20); send_line(LW);
        fill_const(30); send_line(LW);
        frame(-1);

        while (lines.size() < WF+1) begin
            if (in_lines % 2 == 1) fill_const(in_lines); else fill_rand();
            send_line(LW);
        end
        frame(-1);

        fill_rand(); send_line(LW+6);
        check("overflow_set", {31'd0, o_overflow}, 32'd1);
        frame(-1);

`ifndef WF_PEAK_EN
        fill_rand(); send_line(1);
        fill_rand(); send_line(LW/2 + 3);
        frame(-1);
`endif

        frame(5);
        frame(-1);

        while (in_lines % DEC != 0) begin fill_rand(); send_line(LW); end
        for (int j = 0; j < DEC; j++) begin
            fill_rand();
            stim[5] = 8'(pk[j]);
            send_line(LW);
        end
        frame(-1);
        check("overflow_sticky", {31'd0, o_overflow}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
